// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, the core-facing
// valid/ready instruction handshake, and the redirect (flush) port.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  // The fetch unit drives requests and instructions
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, inst_ready, redirect, redirect_pc
  );

  // Memory and core side of the same bus
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle-latency memory
// requests gated by FIFO credit, a prefetch FIFO of {word, pc}, and flush on
// redirect.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = INST_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflightPc_q, inflightPc_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [EW-1:0]         storage_q [FIFO_DEPTH];

  logic                  imemReq;
  logic                  instValid;
  logic                  pushEn;
  logic                  popEn;
  logic [CW:0]           occPlusInflight;
  logic [EW-1:0]         headEntry;

  // Credit counts the in-flight request so a returning word always has a slot;
  // a pop only frees credit once the counter has actually decremented.
  assign occPlusInflight = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imemReq   = !rst && !bus.redirect && (occPlusInflight < (CW+1)'(FIFO_DEPTH));
  assign instValid = (count_q != '0);
  assign pushEn    = !rst && !bus.redirect && inflight_q;
  assign popEn     = instValid && bus.inst_ready;
  assign headEntry = storage_q[rdPtr_q];

  assign bus.imem_req   = imemReq;
  assign bus.imem_addr  = fetchPc_q;
  assign bus.inst_valid = instValid;
  assign bus.inst       = instValid ? headEntry[EW-1:ADDR_WIDTH] : '0;
  assign bus.inst_pc    = instValid ? headEntry[ADDR_WIDTH-1:0] : '0;

  // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect
  // flushes everything and beats any push/pop in the same cycle.
  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflight_d   = imemReq;
    inflightPc_d = fetchPc_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    if (bus.redirect) begin
      fetchPc_d  = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
    end else begin
      if (imemReq) begin
        fetchPc_d = fetchPc_q + ADDR_WIDTH'(4);
      end
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q    <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= RESET_PC;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage: returning word captured together with the PC that fetched it
  always_ff @(posedge clk) begin
    if (pushEn) begin
      storage_q[wrPtr_q] <= {bus.imem_rdata, inflightPc_q};
    end
  end

  // A push into a full FIFO without a matching pop means the credit logic broke
  assert property (@(posedge clk) disable iff (rst)
                   !(pushEn && !popEn && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit; the imem model returns pc+0x100.
module tb_inst_fetch_unit;

  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  inst_fetch_unit #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .FIFO_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous instruction memory with 1-cycle latency
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr + 32'h100;

  // Hold reset, then release it; returns inside cycle 0 (#1 after negedge)
  task automatic startFromReset(input logic readyVal);
    @(negedge clk);
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = readyVal;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%0b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got=%h exp=0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.inst_pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] expPc;
    startFromReset(1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*c)) begin
        errors++; $display("[TB] FAIL seq_req c=%0d got req=%0b addr=%h exp req=1 addr=%h", c, bus.imem_req, bus.imem_addr, 32'(4*c)); end
      if (c < 2) begin
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_early_valid c=%0d got=%0b exp=0", c, bus.inst_valid); end
      end else begin
        expPc = 32'(4*(c-2));
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== expPc || bus.inst !== expPc + 32'h100) begin
          errors++; $display("[TB] FAIL seq_inst c=%0d got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h", c, bus.inst_valid, bus.inst_pc, bus.inst, expPc, expPc + 32'h100); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expPc;
    startFromReset(1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      checks++; if (bus.imem_req !== (c < 4)) begin errors++; $display("[TB] FAIL bp_req c=%0d got=%0b exp=%0b", c, bus.imem_req, (c < 4)); end
      if (c < 4) begin
        checks++; if (bus.imem_addr !== 32'(4*c)) begin errors++; $display("[TB] FAIL bp_addr c=%0d got=%h exp=%h", c, bus.imem_addr, 32'(4*c)); end
      end
      if (c >= 2) begin
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h100) begin
          errors++; $display("[TB] FAIL bp_hold c=%0d got v=%0b pc=%h inst=%h exp v=1 pc=0 inst=100", c, bus.inst_valid, bus.inst_pc, bus.inst); end
      end
    end
    for (int c = 8; c < 15; c++) begin
      @(negedge clk);
      bus.inst_ready = 1'b1;
      #1;
      expPc = 32'(4*(c-8));
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== expPc || bus.inst !== expPc + 32'h100) begin
        errors++; $display("[TB] FAIL bp_drain c=%0d got v=%0b pc=%h inst=%h exp v=1 pc=%h", c, bus.inst_valid, bus.inst_pc, bus.inst, expPc); end
      if (c == 8) begin
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_credit c=8 got req=%0b exp=0", bus.imem_req); end
      end
      if (c == 9) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
          errors++; $display("[TB] FAIL bp_refill c=9 got req=%0b addr=%h exp req=1 addr=10", bus.imem_req, bus.imem_addr); end
      end
    end
  endtask

  // Pulse redirect for one cycle (core ready afterwards) and follow the refetch
  task automatic applyRedirect(input string name, input logic [31:0] pcIn, input logic [31:0] expPc);
    logic [31:0] nextPc;
    nextPc = expPc + 32'h4;
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = pcIn; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL %s_redir_req got=%0b exp=0", name, bus.imem_req); end
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_flush_valid got=%0b exp=0", name, bus.inst_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== expPc) begin
      errors++; $display("[TB] FAIL %s_new_req got req=%0b addr=%h exp req=1 addr=%h", name, bus.imem_req, bus.imem_addr, expPc); end
    @(negedge clk); #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_kill_valid got=%0b exp=0", name, bus.inst_valid); end
    checks++; if (bus.imem_addr !== nextPc) begin errors++; $display("[TB] FAIL %s_next_addr got=%h exp=%h", name, bus.imem_addr, nextPc); end
    @(negedge clk); #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== expPc || bus.inst !== expPc + 32'h100) begin
      errors++; $display("[TB] FAIL %s_first_inst got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h", name, bus.inst_valid, bus.inst_pc, bus.inst, expPc, expPc + 32'h100); end
    @(negedge clk); #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== nextPc || bus.inst !== nextPc + 32'h100) begin
      errors++; $display("[TB] FAIL %s_second_inst got v=%0b pc=%h inst=%h exp v=1 pc=%h", name, bus.inst_valid, bus.inst_pc, bus.inst, nextPc); end
  endtask

  task automatic test_redirect_flush();
    startFromReset(1'b0);
    for (int c = 1; c < 4; c++) begin @(negedge clk); #1; end
    applyRedirect("flush", 32'h200, 32'h200);
  endtask

  task automatic test_redirect_align();
    applyRedirect("align", 32'h203, 32'h200);
  endtask

  task automatic test_redirect_wrap();
    applyRedirect("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h400; bus.inst_ready = 1'b1;
    #1;
    applyRedirect("b2b", 32'h800, 32'h800);
  endtask

  task automatic test_reset_with_redirect();
    startFromReset(1'b0);
    for (int c = 1; c < 7; c++) begin @(negedge clk); #1; end
    @(negedge clk);
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h500;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstredir_req got=%0b exp=0", bus.imem_req); end
    @(negedge clk);
    rst = 1'b0; bus.redirect = 1'b0;
    #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstredir_valid got=%0b exp=0", bus.inst_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL rstredir_addr got req=%0b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h100) begin
      errors++; $display("[TB] FAIL rstredir_inst got v=%0b pc=%h inst=%h exp v=1 pc=0 inst=100", bus.inst_valid, bus.inst_pc, bus.inst); end
  endtask

  // Run every scenario in order and report
  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_redirect_align();
    test_redirect_wrap();
    test_back_to_back();
    test_reset_with_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
